comp_fiber_tx_framer: RTL and testbench

Transmit-side framer for the comparator fiber link: builds the 4-phase, 160 MHz frame stream (one frame per 40 MHz bunch crossing) that the comparator fiber receiver decodes. It produces comma-aligned sync frames after reset, frames 48-bit comparator data, marks latency-trigger frames, and sends the start frame and PRBS test frames used by the receiver's error counter. Its output feeds the 16-bit GTX TX user interface; inputs come from the fabric logic in the same 160 MHz domain.

---
 rtl/comp_fiber_tx_framer.sv | 164 ++++++++++++++++
 tb/tb_comp_fiber_tx_framer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/comp_fiber_tx_framer.sv
// comp_fiber_tx_framer: transmit framer for the comparator fiber link.
// Emits 4-cycle frames (K28.5 header + three 16-bit data words) on the
// 160 MHz GTX TX user interface: sync frames after reset, then comparator
// data / idle / latency-trigger frames, or a start frame followed by PRBS
// test frames.
// Ports:
//   ref_clk, reset          160 MHz clock, async active-high reset
//   din[47:0], din_valid    comparator word and its valid flag
//   din_ready               word accepted when din_valid is also high
//   ltncy_req, inj_err      request pulses (sticky until consumed)
//   en_prbstest             PRBS test-mode level
//   tx_data, tx_charisk     GTX TX word and K-character flags
//   word0                   tx_data carries phase 0 of a frame
//   frame_count             frames started since reset (wrapping)
//   sync_done, prbs_active  status flags
module comp_fiber_tx_framer #(
  parameter int unsigned SYNC_FRAMES = 64,
  parameter logic [15:0] PRBS_SEED   = 16'hACE1
) (
  input  logic        ref_clk,
  input  logic        reset,
  input  logic [47:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        ltncy_req,
  input  logic        en_prbstest,
  input  logic        inj_err,
  output logic [15:0] tx_data,
  output logic [1:0]  tx_charisk,
  output logic        word0,
  output logic [7:0]  frame_count,
  output logic        sync_done,
  output logic        prbs_active
);

  localparam int unsigned DATA_W = 48;
  localparam int unsigned CNT_W  = 16;

  localparam logic [7:0] K28_5      = 8'hBC;
  localparam logic [7:0] CTRL_IDLE  = 8'h50;
  localparam logic [7:0] CTRL_DATA  = 8'hDA;
  localparam logic [7:0] CTRL_FC    = 8'hFC;
  localparam logic [7:0] CTRL_START = 8'hF7;
  localparam logic [7:0] CTRL_PRBS  = 8'hA5;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_RUN   = 2'd1,
    ST_START = 2'd2,
    ST_PRBS  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_nxt_state;
  logic [1:0]          r_phase;
  logic [CNT_W-1:0]    r_sync_cnt;
  logic [DATA_W-1:0]   r_data;
  logic [15:0]         r_lfsr;
  logic                r_en_smp;
  logic                r_ltncy;
  logic                r_inj;
  logic                w_boundary;
  logic                w_sync_last;
  logic                w_take;
  logic [7:0]          w_nxt_ctrl;
  logic [DATA_W-1:0]   w_nxt_data;
  logic [15:0]         w_lfsr_nxt;

  assign w_boundary  = (r_phase == 2'd3);
  assign w_sync_last = (r_sync_cnt == CNT_W'(SYNC_FRAMES));
  // din_ready is only ever high in the phase-3 cycle, so this is the capture
  assign w_take      = din_valid & din_ready;
  assign w_lfsr_nxt  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  // State register
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) r_state <= ST_SYNC;
    else       r_state <= w_nxt_state;
  end

  // Next-state and next-frame content; only acted on at the frame boundary.
  // Mode decisions use en_prbstest as sampled entering phase 3, so that the
  // registered din_ready in that cycle already reflects a pending START.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ctrl  = CTRL_IDLE;
    w_nxt_data  = '0;
    if (w_boundary) begin
      unique case (r_state)
        ST_SYNC:  if (w_sync_last) w_nxt_state = r_en_smp ? ST_START : ST_RUN;
        ST_RUN:   if (r_en_smp)    w_nxt_state = ST_START;
        ST_START: w_nxt_state = ST_PRBS;
        ST_PRBS:  if (!r_en_smp)   w_nxt_state = ST_RUN;
        default:  w_nxt_state = ST_SYNC;
      endcase
    end
    unique case (w_nxt_state)
      ST_RUN: begin
        if (w_take) begin
          w_nxt_ctrl = CTRL_DATA;
          w_nxt_data = din;
        end
        if (r_ltncy) w_nxt_ctrl = CTRL_FC;
      end
      ST_START: w_nxt_ctrl = CTRL_START;
      ST_PRBS: begin
        w_nxt_ctrl = CTRL_PRBS;
        w_nxt_data = {r_lfsr, ~r_lfsr, r_lfsr[15:1], r_lfsr[0] ^ r_inj};
      end
      default: ;
    endcase
  end

  // Framing datapath and registered outputs
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      r_phase     <= 2'd0;
      r_sync_cnt  <= CNT_W'(1);
      r_data      <= '0;
      r_lfsr      <= PRBS_SEED;
      r_en_smp    <= 1'b0;
      r_ltncy     <= 1'b0;
      r_inj       <= 1'b0;
      tx_data     <= {CTRL_IDLE, K28_5};
      tx_charisk  <= 2'b01;
      word0       <= 1'b1;
      din_ready   <= 1'b0;
      frame_count <= 8'd0;
      sync_done   <= 1'b0;
      prbs_active <= 1'b0;
    end else begin
      r_phase   <= r_phase + 2'd1;
      din_ready <= (r_phase == 2'd2) && (r_state == ST_RUN) && !en_prbstest;
      if (r_phase == 2'd2) r_en_smp <= en_prbstest;

      if (w_boundary) begin
        r_data      <= w_nxt_data;
        tx_data     <= {w_nxt_ctrl, K28_5};
        tx_charisk  <= 2'b01;
        word0       <= 1'b1;
        frame_count <= frame_count + 8'd1;
        prbs_active <= (w_nxt_state == ST_START) || (w_nxt_state == ST_PRBS);
        if (r_state == ST_SYNC && w_nxt_state != ST_SYNC) sync_done <= 1'b1;
        if (r_state == ST_SYNC && w_nxt_state == ST_SYNC) r_sync_cnt <= r_sync_cnt + CNT_W'(1);
        // Latches are consumed (or dropped) here; a same-cycle pulse survives
        r_ltncy <= (w_nxt_state == ST_SYNC) ? (r_ltncy | ltncy_req) : ltncy_req;
        r_inj   <= inj_err;
        if (w_nxt_state == ST_START)     r_lfsr <= PRBS_SEED;
        else if (w_nxt_state == ST_PRBS) r_lfsr <= w_lfsr_nxt;
      end else begin
        unique case (r_phase)
          2'd0:    tx_data <= r_data[15:0];
          2'd1:    tx_data <= r_data[31:16];
          default: tx_data <= r_data[47:32];
        endcase
        tx_charisk <= 2'b00;
        word0      <= 1'b0;
        r_ltncy    <= r_ltncy | ltncy_req;
        r_inj      <= r_inj | inj_err;
      end
    end
  end

endmodule

// File: tb/tb_comp_fiber_tx_framer.sv
// tb_comp_fiber_tx_framer: directed bench for comp_fiber_tx_framer with
// SYNC_FRAMES=4. Walks sync, data, latency, PRBS start/sequence, error
// injection and mid-frame reset, checking every output word.
module tb_comp_fiber_tx_framer;

  logic        ref_clk;
  logic        reset;
  logic [47:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        ltncy_req;
  logic        en_prbstest;
  logic        inj_err;
  logic [15:0] tx_data;
  logic [1:0]  tx_charisk;
  logic        word0;
  logic [7:0]  frame_count;
  logic        sync_done;
  logic        prbs_active;

  int n_vec = 0;
  int n_err = 0;

  comp_fiber_tx_framer #(.SYNC_FRAMES(4), .PRBS_SEED(16'hACE1)) dut (
    .ref_clk     (ref_clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .ltncy_req   (ltncy_req),
    .en_prbstest (en_prbstest),
    .inj_err     (inj_err),
    .tx_data     (tx_data),
    .tx_charisk  (tx_charisk),
    .word0       (word0),
    .frame_count (frame_count),
    .sync_done   (sync_done),
    .prbs_active (prbs_active)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish, expected finish before 50000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".tx_data"}, 64'(tx_data), 64'h50BC);
    check({tag, ".charisk"}, 64'(tx_charisk), 64'd1);
    check({tag, ".word0"}, 64'(word0), 64'd1);
    check({tag, ".din_ready"}, 64'(din_ready), 64'd0);
    check({tag, ".frame_count"}, 64'(frame_count), 64'd0);
    check({tag, ".sync_done"}, 64'(sync_done), 64'd0);
    check({tag, ".prbs_active"}, 64'(prbs_active), 64'd0);
  endtask

  // Entry: sampling a header cycle. Exit: sampling the next header cycle.
  task automatic check_frame(input string tag, input logic [7:0] ctrl, input logic [47:0] data,
                             input logic dr3, input logic [7:0] fc, input logic sd, input logic pa,
                             input logic pl, input logic pi);
    check({tag, ".hdr"}, 64'(tx_data), 64'({ctrl, 8'hBC}));
    check({tag, ".hdr.k"}, 64'(tx_charisk), 64'd1);
    check({tag, ".hdr.w0"}, 64'(word0), 64'd1);
    check({tag, ".hdr.rdy"}, 64'(din_ready), 64'd0);
    check({tag, ".hdr.fc"}, 64'(frame_count), 64'(fc));
    check({tag, ".hdr.sd"}, 64'(sync_done), 64'(sd));
    check({tag, ".hdr.pa"}, 64'(prbs_active), 64'(pa));
    @(negedge ref_clk);
    check({tag, ".p1"}, 64'(tx_data), 64'(data[15:0]));
    check({tag, ".p1.k"}, 64'(tx_charisk), 64'd0);
    check({tag, ".p1.w0"}, 64'(word0), 64'd0);
    check({tag, ".p1.rdy"}, 64'(din_ready), 64'd0);
    ltncy_req = pl;
    inj_err   = pi;
    @(negedge ref_clk);
    ltncy_req = 1'b0;
    inj_err   = 1'b0;
    check({tag, ".p2"}, 64'(tx_data), 64'(data[31:16]));
    check({tag, ".p2.rdy"}, 64'(din_ready), 64'd0);
    @(negedge ref_clk);
    check({tag, ".p3"}, 64'(tx_data), 64'(data[47:32]));
    check({tag, ".p3.w0"}, 64'(word0), 64'd0);
    check({tag, ".p3.rdy"}, 64'(din_ready), 64'(dr3));
    check({tag, ".p3.pa"}, 64'(prbs_active), 64'(pa));
    @(negedge ref_clk);
  endtask

  initial begin
    reset       = 1'b1;
    din         = '0;
    din_valid   = 1'b0;
    ltncy_req   = 1'b0;
    en_prbstest = 1'b0;
    inj_err     = 1'b0;
    @(negedge ref_clk);
    @(negedge ref_clk);
    check_reset_vals("rst");
    reset = 1'b0;

    // Sync: frame held in reset is frame 1 of 4
    check_frame("sync1", 8'h50, 48'h0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("sync2", 8'h50, 48'h0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("sync3", 8'h50, 48'h0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("sync4", 8'h50, 48'h0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // First RUN frame: idle, accepts the word in its phase-3 cycle
    din       = 48'h123456789ABC;
    din_valid = 1'b1;
    check_frame("run5", 8'h50, 48'h0, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    din_valid = 1'b0;
    check_frame("data6", 8'hDA, 48'h123456789ABC, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0);

    // Latency request mid-frame, no data
    check_frame("idle7", 8'h50, 48'h0, 1'b1, 8'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    check_frame("fc8", 8'hFC, 48'h0, 1'b1, 8'd7, 1'b1, 1'b0, 1'b0, 1'b0);

    // PRBS entry; a latency request at the same boundary is dropped
    en_prbstest = 1'b1;
    check_frame("idle9", 8'h50, 48'h0, 1'b0, 8'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    check_frame("start10", 8'hF7, 48'h0, 1'b0, 8'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    check_frame("prbs11", 8'hA5, 48'hACE1_531E_ACE1, 1'b0, 8'd10, 1'b1, 1'b1, 1'b0, 1'b0);
    check_frame("prbs12", 8'hA5, 48'h59C3_A63C_59C3, 1'b0, 8'd11, 1'b1, 1'b1, 1'b0, 1'b1);
    check_frame("prbs13_inj", 8'hA5, 48'hB387_4C78_B386, 1'b0, 8'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    en_prbstest = 1'b0;
    check_frame("prbs14", 8'hA5, 48'h670F_98F0_670F, 1'b0, 8'd13, 1'b1, 1'b1, 1'b0, 1'b0);

    // Back to RUN: idle (earlier latency request gone), then a data frame
    din       = 48'hFEDCBA987654;
    din_valid = 1'b1;
    check_frame("run15", 8'h50, 48'h0, 1'b1, 8'd14, 1'b1, 1'b0, 1'b0, 1'b0);

    // Data frame interrupted by reset at phase 2
    check("data16.hdr", 64'(tx_data), 64'hDABC);
    check("data16.fc", 64'(frame_count), 64'd15);
    @(negedge ref_clk);
    check("data16.p1", 64'(tx_data), 64'h7654);
    @(negedge ref_clk);
    check("data16.p2", 64'(tx_data), 64'hBA98);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge ref_clk);
    @(negedge ref_clk);
    check_reset_vals("midrst_hold");
    reset = 1'b0;

    // din_valid held high: din_ready must stay low through sync
    check_frame("rsync1", 8'h50, 48'h0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("rsync2", 8'h50, 48'h0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("rsync3", 8'h50, 48'h0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("rsync4", 8'h50, 48'h0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("rrun5", 8'h50, 48'h0, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    check_frame("rdata6", 8'hDA, 48'hFEDCBA987654, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    din_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
